// File: rtl/sccb_pkg.sv
// Shared state encoding and framing constants for the SCCB three-phase write engine.
package sccb_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    BIT,
    STOP,
    GAP
  } state_t;

  localparam int START_Q       = 2;
  localparam int BIT_Q         = 4;
  localparam int STOP_Q        = 4;
  localparam int GAP_Q         = 4;
  localparam int BITS_PER_BYTE = 9;
  localparam int BYTES         = 3;

  localparam logic [7:0] DEFAULT_CAM_ID = 8'h42;

endpackage

// File: rtl/sccb_tick_gen.sv
// Quarter-period divider: one-cycle tick every QTR clocks, held at zero while clear is high.
module sccb_tick_gen #(
  parameter int QTR = 250
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick
);

  localparam int CW = (QTR > 1) ? $clog2(QTR) : 1;

  logic [CW-1:0] count;

  generate
    if (QTR < 2) begin : g_qtr_check
      $error("sccb_tick_gen: QTR must be at least 2");
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear || tick) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = !clear && (count == CW'(QTR - 1));

endmodule

// File: rtl/sccb_master.sv
// SCCB write engine: sends CAM_ID, register address and data as three 9-bit phases,
// then a stop condition and bus-free gap before reporting ready again.
module sccb_master
  import sccb_pkg::*;
#(
  parameter int         CLK_F  = 100_000_000,
  parameter int         SCCB_F = 100_000,
  parameter logic [7:0] CAM_ID = DEFAULT_CAM_ID
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [7:0] i_addr,
  input  logic [7:0] i_data,
  input  logic       i_siod,
  output logic       o_ready,
  output logic       o_sioc,
  output logic       o_siod,
  output logic       o_siod_oe,
  output logic       o_nack
);

  localparam int         QTR       = CLK_F / (4 * SCCB_F);
  localparam logic [3:0] LAST_BIT  = 4'(BITS_PER_BYTE - 1);
  localparam logic [3:0] PRE_X_BIT = 4'(BITS_PER_BYTE - 2);
  localparam logic [1:0] LAST_BYTE = 2'(BYTES - 1);
  localparam logic [1:0] START_END = 2'(START_Q - 1);
  localparam logic [1:0] BIT_END   = 2'(BIT_Q - 1);
  localparam logic [1:0] STOP_END  = 2'(STOP_Q - 1);
  localparam logic [1:0] GAP_END   = 2'(GAP_Q - 1);

  state_t      state, state_n;
  logic [1:0]  qcnt, qcnt_n;
  logic [3:0]  bit_idx, bit_idx_n;
  logic [1:0]  byte_idx, byte_idx_n;
  logic [23:0] shift, shift_n;
  logic        nack_flag, nack_flag_n;
  logic        ready_n, sioc_n, siod_n, oe_n, nack_n;
  logic        tick;

  sccb_tick_gen #(.QTR(QTR)) u_tick (
    .clk   (i_clk),
    .rst   (i_rst),
    .clear (state == IDLE),
    .tick  (tick)
  );

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= IDLE;
      qcnt      <= '0;
      bit_idx   <= '0;
      byte_idx  <= '0;
      shift     <= '0;
      nack_flag <= 1'b0;
      o_ready   <= 1'b1;
      o_sioc    <= 1'b1;
      o_siod    <= 1'b1;
      o_siod_oe <= 1'b1;
      o_nack    <= 1'b0;
    end else begin
      state     <= state_n;
      qcnt      <= qcnt_n;
      bit_idx   <= bit_idx_n;
      byte_idx  <= byte_idx_n;
      shift     <= shift_n;
      nack_flag <= nack_flag_n;
      o_ready   <= ready_n;
      o_sioc    <= sioc_n;
      o_siod    <= siod_n;
      o_siod_oe <= oe_n;
      o_nack    <= nack_n;
    end
  end

  // Line values are computed for the quarter being entered, so every output stays registered.
  always_comb begin
    state_n     = state;
    qcnt_n      = qcnt;
    bit_idx_n   = bit_idx;
    byte_idx_n  = byte_idx;
    shift_n     = shift;
    nack_flag_n = nack_flag;
    ready_n     = o_ready;
    sioc_n      = o_sioc;
    siod_n      = o_siod;
    oe_n        = o_siod_oe;
    nack_n      = 1'b0;

    case (state)
      IDLE: begin
        if (i_start) begin
          shift_n     = {CAM_ID, i_addr, i_data};
          nack_flag_n = 1'b0;
          ready_n     = 1'b0;
          qcnt_n      = '0;
          sioc_n      = 1'b1;
          siod_n      = 1'b1;
          oe_n        = 1'b1;
          state_n     = START;
        end
      end

      START: begin
        if (tick) begin
          if (qcnt == START_END) begin
            state_n    = BIT;
            qcnt_n     = '0;
            bit_idx_n  = '0;
            byte_idx_n = '0;
            sioc_n     = 1'b0;
            siod_n     = shift[23];
            shift_n    = {shift[22:0], 1'b0};
          end else begin
            qcnt_n = qcnt + 2'd1;
            siod_n = 1'b0;
          end
        end
      end

      BIT: begin
        if (tick) begin
          qcnt_n = qcnt + 2'd1;
          if (qcnt == 2'd1) begin
            sioc_n = 1'b1;
          end else if (qcnt == 2'd2) begin
            if (bit_idx == LAST_BIT && i_siod) begin
              nack_flag_n = 1'b1;
            end
          end else if (qcnt == BIT_END) begin
            qcnt_n = '0;
            sioc_n = 1'b0;
            if (bit_idx == LAST_BIT) begin
              bit_idx_n = '0;
              oe_n      = 1'b1;
              if (byte_idx == LAST_BYTE) begin
                state_n = STOP;
                siod_n  = 1'b0;
              end else begin
                byte_idx_n = byte_idx + 2'd1;
                siod_n     = shift[23];
                shift_n    = {shift[22:0], 1'b0};
              end
            end else if (bit_idx == PRE_X_BIT) begin
              // The X bit belongs to the slave: release the line for its full four quarters.
              bit_idx_n = bit_idx + 4'd1;
              oe_n      = 1'b0;
              siod_n    = 1'b1;
            end else begin
              bit_idx_n = bit_idx + 4'd1;
              siod_n    = shift[23];
              shift_n   = {shift[22:0], 1'b0};
            end
          end
        end
      end

      STOP: begin
        if (tick) begin
          if (qcnt == STOP_END) begin
            state_n = GAP;
            qcnt_n  = '0;
          end else begin
            qcnt_n = qcnt + 2'd1;
            if (qcnt == 2'd0) begin
              sioc_n = 1'b1;
            end else if (qcnt == 2'd1) begin
              siod_n = 1'b1;
            end
          end
        end
      end

      GAP: begin
        if (tick) begin
          if (qcnt == GAP_END) begin
            state_n = IDLE;
            qcnt_n  = '0;
            ready_n = 1'b1;
            nack_n  = nack_flag;
          end else begin
            qcnt_n = qcnt + 2'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_sccb_master.sv
// Self-checking bench for sccb_master: bus decoder/slave model, protocol checker and scenario tasks.
module tb_sccb_master;

  localparam int         CLK_F      = 4_000_000;
  localparam int         SCCB_F     = 100_000;
  localparam int         QTR        = CLK_F / (4 * SCCB_F);
  localparam logic [7:0] CAM_ID     = 8'h42;
  localparam int         TXN_CYCLES = 118 * QTR;
  localparam int         WAIT_LIMIT = TXN_CYCLES + 40;
  localparam int         OE_LOW     = 3 * 4 * QTR;

  logic       clk   = 1'b0;
  logic       rst   = 1'b0;
  logic       start = 1'b0;
  logic [7:0] addr  = 8'h00;
  logic [7:0] data  = 8'h00;
  logic       pad;
  logic       slave_val;
  logic       ready, sioc, siod, siod_oe, nack;

  int n_checks = 0;
  int n_fail   = 0;

  logic [2:0]  slave_x    = 3'b000;
  bit          in_txn     = 1'b0;
  int          rcount     = 0;
  int          oe_low_cnt = 0;
  int          level_len  = 0;
  logic        prev_sioc  = 1'b1;
  logic        prev_pad   = 1'b1;
  logic [7:0]  mbytes [3];
  logic [23:0] got_q [$];

  always #5 clk = ~clk;

  sccb_master #(
    .CLK_F  (CLK_F),
    .SCCB_F (SCCB_F),
    .CAM_ID (CAM_ID)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_addr    (addr),
    .i_data    (data),
    .i_siod    (pad),
    .o_ready   (ready),
    .o_sioc    (sioc),
    .o_siod    (siod),
    .o_siod_oe (siod_oe),
    .o_nack    (nack)
  );

  // Slave drives its X-bit answer from the 8th SIOC rise of a byte until SIOC falls after the 9th.
  always_comb begin
    slave_val = 1'b1;
    for (int k = 0; k < 3; k++) begin
      if (in_txn && ((rcount == 9 * k + 8) || (rcount == 9 * k + 9 && sioc == 1'b1))) begin
        slave_val = slave_x[k];
      end
    end
  end

  assign pad = siod_oe ? siod : slave_val;

  // Bus decoder and protocol checker, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst) begin
      in_txn = 1'b0;
      rcount = 0;
    end else begin
      if (siod_oe === 1'b0) oe_low_cnt++;
      if (prev_sioc && sioc && prev_pad && !pad) begin
        n_checks++;
        if (in_txn) begin
          n_fail++;
          $display("[TB] FAIL proto_start: start seen after %0d bits, required idle bus", rcount);
        end
        in_txn = 1'b1;
        rcount = 0;
        mbytes[0] = 8'h00; mbytes[1] = 8'h00; mbytes[2] = 8'h00;
      end else if (prev_sioc && sioc && !prev_pad && pad) begin
        n_checks++;
        if (!in_txn || rcount != 27) begin
          n_fail++;
          $display("[TB] FAIL proto_stop: stop after %0d bits (in_txn=%0d), required 27 bits", rcount, in_txn);
        end
        if (in_txn) got_q.push_back({mbytes[0], mbytes[1], mbytes[2]});
        in_txn = 1'b0;
      end
      if (!prev_sioc && sioc && in_txn) begin
        n_checks++;
        if (pad !== prev_pad) begin
          n_fail++;
          $display("[TB] FAIL proto_setup: SIOD changed with SIOC rise (%b -> %b), required stable", prev_pad, pad);
        end
        if (rcount < 27) begin
          n_checks++;
          if (level_len != 2 * QTR) begin
            n_fail++;
            $display("[TB] FAIL sioc_low: low period %0d cycles, required %0d", level_len, 2 * QTR);
          end
          if (rcount % 9 < 8) begin
            mbytes[rcount / 9] = {mbytes[rcount / 9][6:0], pad};
          end else begin
            n_checks++;
            if (siod_oe !== 1'b0) begin
              n_fail++;
              $display("[TB] FAIL xbit_oe: oe=%b during X bit %0d, required 0", siod_oe, rcount / 9);
            end
          end
          rcount++;
        end
      end
      if (prev_sioc && !sioc && in_txn && rcount >= 1) begin
        n_checks++;
        if (level_len != 2 * QTR) begin
          n_fail++;
          $display("[TB] FAIL sioc_high: high period %0d cycles, required %0d", level_len, 2 * QTR);
        end
      end
    end
    if (sioc !== prev_sioc) level_len = 1;
    else level_len++;
    prev_sioc = sioc;
    prev_pad  = pad;
  end

  task automatic launch(input logic [7:0] a, input logic [7:0] d);
    addr       = a;
    data       = d;
    oe_low_cnt = 0;
    start      = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_done(output int busy, output int nacks, output bit nack_at_rise);
    busy  = 0;
    nacks = 0;
    while (ready !== 1'b1 && busy < WAIT_LIMIT) begin
      @(posedge clk); #1;
      busy++;
      if (nack === 1'b1) nacks++;
    end
    nack_at_rise = (ready === 1'b1) && (nack === 1'b1);
  endtask

  task automatic test_reset;
    rst = 1'b0;
    #1 rst = 1'b1;
    #2;
    n_checks++;
    if ({ready, sioc, siod, siod_oe, nack} !== 5'b11110) begin
      n_fail++;
      $display("[TB] FAIL reset_values: got %b, required 11110", {ready, sioc, siod, siod_oe, nack});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    n_checks++;
    if ({ready, sioc, siod, siod_oe, nack} !== 5'b11110) begin
      n_fail++;
      $display("[TB] FAIL idle_after_reset: got %b, required 11110", {ready, sioc, siod, siod_oe, nack});
    end
  endtask

  task automatic test_single_write;
    int busy, nacks;
    bit nar;
    got_q.delete();
    slave_x = 3'b000;
    launch(8'h12, 8'h80);
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL accept_ready: ready=%b after accept, required 0", ready);
    end
    wait_done(busy, nacks, nar);
    n_checks++;
    if (busy != TXN_CYCLES) begin
      n_fail++;
      $display("[TB] FAIL single_busy: ready low %0d cycles, required %0d", busy, TXN_CYCLES);
    end
    n_checks++;
    if (nacks != 0) begin
      n_fail++;
      $display("[TB] FAIL single_nack: %0d nack pulses, required 0", nacks);
    end
    n_checks++;
    if (got_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL single_count: %0d transactions decoded, required 1", got_q.size());
    end else if (got_q[0] !== {CAM_ID, 8'h12, 8'h80}) begin
      n_fail++;
      $display("[TB] FAIL single_bytes: got %h, required %h", got_q[0], {CAM_ID, 8'h12, 8'h80});
    end
    n_checks++;
    if (oe_low_cnt != OE_LOW) begin
      n_fail++;
      $display("[TB] FAIL single_oe_low: %0d released cycles, required %0d", oe_low_cnt, OE_LOW);
    end
  endtask

  task automatic test_handshake;
    int cyc;
    logic [7:0] d1, d2;
    got_q.delete();
    slave_x = 3'b000;
    d1 = 8'($urandom);
    d2 = 8'($urandom);
    addr  = 8'h11;
    data  = d1;
    start = 1'b1;
    @(posedge clk); #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL hs_first_accept: ready=%b, required 0", ready);
    end
    addr = 8'h40;
    data = d2;
    cyc  = 0;
    while (ready !== 1'b1 && cyc < WAIT_LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != TXN_CYCLES) begin
      n_fail++;
      $display("[TB] FAIL hs_first_busy: %0d cycles, required %0d", cyc, TXN_CYCLES);
    end
    @(posedge clk); #1;
    n_checks++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL hs_second_accept: ready=%b one cycle after rise, required 0", ready);
    end
    start = 1'b0;
    cyc   = 0;
    while (ready !== 1'b1 && cyc < WAIT_LIMIT) begin
      @(posedge clk); #1;
      cyc++;
    end
    n_checks++;
    if (cyc != TXN_CYCLES) begin
      n_fail++;
      $display("[TB] FAIL hs_second_busy: %0d cycles, required %0d", cyc, TXN_CYCLES);
    end
    repeat (20) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1 || got_q.size() != 2) begin
      n_fail++;
      $display("[TB] FAIL hs_count: ready=%b transactions=%0d, required ready=1 and 2", ready, got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== {CAM_ID, 8'h11, d1} || got_q[1] !== {CAM_ID, 8'h40, d2}) begin
        n_fail++;
        $display("[TB] FAIL hs_bytes: got %h %h, required %h %h", got_q[0], got_q[1],
                 {CAM_ID, 8'h11, d1}, {CAM_ID, 8'h40, d2});
      end
    end
  endtask

  task automatic test_busy_request;
    int busy, nacks;
    bit nar;
    logic [7:0] d;
    got_q.delete();
    slave_x = 3'b000;
    d = 8'($urandom);
    launch(8'h5A, d);
    repeat (40 * QTR) @(posedge clk);
    #1;
    addr  = 8'hFF;
    data  = ~d;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_done(busy, nacks, nar);
    n_checks++;
    if (40 * QTR + 1 + busy != TXN_CYCLES) begin
      n_fail++;
      $display("[TB] FAIL busy_len: %0d cycles, required %0d", 40 * QTR + 1 + busy, TXN_CYCLES);
    end
    repeat (10) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1 || got_q.size() != 1) begin
      n_fail++;
      $display("[TB] FAIL busy_ignored: ready=%b transactions=%0d, required ready=1 and 1", ready, got_q.size());
    end else begin
      n_checks++;
      if (got_q[0] !== {CAM_ID, 8'h5A, d}) begin
        n_fail++;
        $display("[TB] FAIL busy_bytes: got %h, required %h", got_q[0], {CAM_ID, 8'h5A, d});
      end
    end
  endtask

  task automatic test_x_bit;
    int busy, nacks;
    bit nar;
    logic [7:0] a, d;
    got_q.delete();
    slave_x = 3'b100;
    a = 8'($urandom);
    d = 8'($urandom);
    launch(a, d);
    wait_done(busy, nacks, nar);
    n_checks++;
    if (nacks != 1 || !nar) begin
      n_fail++;
      $display("[TB] FAIL x_nack: %0d pulses, at ready rise=%0d, required 1 and 1", nacks, nar);
    end
    n_checks++;
    if (oe_low_cnt != OE_LOW) begin
      n_fail++;
      $display("[TB] FAIL x_oe_low: %0d released cycles, required %0d", oe_low_cnt, OE_LOW);
    end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== {CAM_ID, a, d}) begin
      n_fail++;
      $display("[TB] FAIL x_bytes: %0d transactions, required 1 with %h", got_q.size(), {CAM_ID, a, d});
    end
    @(posedge clk); #1;
    n_checks++;
    if (nack !== 1'b0) begin
      n_fail++;
      $display("[TB] FAIL x_nack_width: nack=%b one cycle later, required 0", nack);
    end
    slave_x = 3'b000;
  endtask

  task automatic test_reset_mid;
    int busy, nacks;
    bit nar;
    logic [7:0] a, d;
    got_q.delete();
    slave_x = 3'b000;
    launch(8'h3C, 8'hC3);
    repeat (30 * QTR) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_checks++;
    if ({ready, sioc, siod, siod_oe} !== 4'b1111) begin
      n_fail++;
      $display("[TB] FAIL async_reset: got %b, required 1111", {ready, sioc, siod, siod_oe});
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    n_checks++;
    if (ready !== 1'b1 || got_q.size() != 0) begin
      n_fail++;
      $display("[TB] FAIL abort_idle: ready=%b transactions=%0d, required 1 and 0", ready, got_q.size());
    end
    a = 8'($urandom);
    d = 8'($urandom);
    launch(a, d);
    wait_done(busy, nacks, nar);
    n_checks++;
    if (busy != TXN_CYCLES || nacks != 0) begin
      n_fail++;
      $display("[TB] FAIL post_abort_txn: busy=%0d nacks=%0d, required %0d and 0", busy, nacks, TXN_CYCLES);
    end
    n_checks++;
    if (got_q.size() != 1 || got_q[0] !== {CAM_ID, a, d}) begin
      n_fail++;
      $display("[TB] FAIL post_abort_bytes: %0d transactions, required 1 with %h", got_q.size(), {CAM_ID, a, d});
    end
  endtask

  task automatic test_random;
    int busy, nacks;
    bit nar;
    logic [7:0] a, d;
    logic [2:0] x;
    for (int i = 0; i < 4; i++) begin
      got_q.delete();
      a = 8'($urandom);
      d = 8'($urandom);
      x = ($urandom_range(0, 1) == 0) ? 3'b000 : 3'($urandom_range(1, 7));
      slave_x = x;
      launch(a, d);
      wait_done(busy, nacks, nar);
      n_checks++;
      if (busy != TXN_CYCLES) begin
        n_fail++;
        $display("[TB] FAIL rand_busy[%0d]: %0d cycles, required %0d", i, busy, TXN_CYCLES);
      end
      n_checks++;
      if (nacks != ((x != 3'b000) ? 1 : 0) || nar != (x != 3'b000)) begin
        n_fail++;
        $display("[TB] FAIL rand_nack[%0d]: pulses=%0d at_rise=%0d, required %0d (x=%b)", i, nacks, nar,
                 (x != 3'b000) ? 1 : 0, x);
      end
      n_checks++;
      if (got_q.size() != 1 || got_q[0] !== {CAM_ID, a, d}) begin
        n_fail++;
        $display("[TB] FAIL rand_bytes[%0d]: %0d transactions, required 1 with %h", i, got_q.size(), {CAM_ID, a, d});
      end
      n_checks++;
      if (oe_low_cnt != OE_LOW) begin
        n_fail++;
        $display("[TB] FAIL rand_oe_low[%0d]: %0d released cycles, required %0d", i, oe_low_cnt, OE_LOW);
      end
      @(posedge clk); #1;
    end
    slave_x = 3'b000;
  endtask

  initial begin
    #600_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    $display("[TB] sccb_master bench, QTR=%0d", QTR);
    test_reset();
    test_single_write();
    test_handshake();
    test_busy_request();
    test_x_bit();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/sccb_master.md
# sccb_master

Three-phase SCCB write engine for the OV7670 register interface. Sits directly downstream of the camera configuration sequencer and consumes its start / register-address / register-data requests. It serialises each request as camera write ID, register address and data onto SIO_C/SIO_D, then returns `o_ready`. The SIO_D tristate buffer lives at the top level, outside this block.

## Interface

Parameters:
- `CLK_F`, 100_000_000: system clock frequency in Hz.
- `SCCB_F`, 100_000: SIO_C frequency in Hz.
- `CAM_ID`, 8'h42: OV7670 write ID, sent as phase 1.

Ports:
- `i_clk`, in, 1: system clock. The block uses one clock only.
- `i_rst`, in, 1: reset, asynchronous, active-high.
- `i_start`, in, 1: request strobe. It is honoured only while `o_ready` = 1.
- `i_addr`, in, 8: register address, latched on accept.
- `i_data`, in, 8: register data, latched on accept.
- `i_siod`, in, 1: SIO_D pad readback, used to sample the don't-care (X) bit.
- `o_ready`, out, 1: high when idle and able to accept a request.
- `o_sioc`, out, 1: SIO_C.
- `o_siod`, out, 1: SIO_D output value.
- `o_siod_oe`, out, 1: SIO_D output enable. 1 = drive, 0 = release.
- `o_nack`, out, 1: one-cycle pulse at the end of a transaction if any X-bit sample read 1.

## Operation

- **Reset values:** `o_ready`=1, `o_sioc`=1, `o_siod`=1, `o_siod_oe`=1, `o_nack`=0, state IDLE.
- **Quarter tick:** QTR = CLK_F/(4*SCCB_F), truncated; elaboration fails if QTR < 2. A divider counts 0..QTR-1 and emits a one-cycle `tick` on the count of QTR-1. The divider is held at 0 in IDLE.
- **Accept:** in IDLE with `i_start`=1:
  - latch `i_addr` and `i_data`;
  - clear the nack flag;
  - deassert `o_ready` at that same edge;
  - go to START.
- **Requests while busy:** `i_start` is ignored while `o_ready`=0, with no queuing. This guarantees the sequencer never sees `o_ready` high the cycle after it pulses start.
- **START (2 quarters):**
  - Q0: SIOC=1, SIOD=1.
  - Q1: SIOC=1, SIOD=0 (start condition).
- **BIT (27 bits):** three bytes, MSB first: CAM_ID, addr, data. Each bit is 4 quarters:
  - Q0: SIOC=0, SIOD updated.
  - Q1: SIOC=0.
  - Q2: SIOC=1.
  - Q3: SIOC=1.
- **X bit:** bit 9 of each byte.
  - `o_siod_oe`=0 for all 4 quarters.
  - `i_siod` is sampled on the tick ending Q2.
  - A sampled 1 sets the nack flag.
- **STOP (4 quarters), `o_siod_oe`=1:**
  - Q0: SIOC=0, SIOD=0.
  - Q1: SIOC=1, SIOD=0.
  - Q2 and Q3: SIOC=1, SIOD=1.
- **GAP (4 quarters):** bus-free time, SIOC=1, SIOD=1.
- **Return to IDLE:** on the last GAP tick, go to IDLE and set `o_ready`=1. `o_nack` pulses in the same cycle if the flag is set.
- **State transitions:** IDLE→START→BIT→STOP→GAP→IDLE.
  - BIT uses a 2-bit quarter counter, a 4-bit bit index (0..8) and a 2-bit byte index (0..2).
  - The last X bit of byte 2 leads to STOP.
- **Reset mid-transaction:** aborts immediately. All outputs take their reset values asynchronously. No stop condition is generated; the camera resynchronises on the next start.

## Timing

- **Outputs:** all outputs are registered.
- **Line changes:** SIOC/SIOD change only on tick edges.
- **Transaction length:** from the accept edge to the `o_ready` rise is exactly 118*QTR cycles (2 + 108 + 4 + 4 quarters). At the defaults, QTR=250, giving 29,500 cycles.
- **Back-to-back requests:** the earliest next accept is the edge after `o_ready` rises.
- **Data-stable guarantee:** SIOD never changes while SIOC=1, except for the start (START Q1) and stop (STOP Q2) edges.

## Structure

- **Package `sccb_pkg`:**
  - state enum (IDLE, START, BIT, STOP, GAP);
  - quarter counts: START_Q=2, BIT_Q=4, STOP_Q=4, GAP_Q=4;
  - BITS_PER_BYTE=9, BYTES=3;
  - default `CAM_ID` 8'h42.
- **Sub-module `sccb_tick_gen`:** parameterised by QTR, with a clear input; outputs `tick`.
- **Main FSM:** the shift register and FSM stay in `sccb_master`.

## Test plan

- **Reset:**
  - Stimulus: assert `i_rst` asynchronously mid-BIT.
  - Response: same instant `o_ready`=1, SIOC=1, SIOD=1, `o_siod_oe`=1. The next transaction completes normally.
- **Single write (SCCB slave model drives X=0, QTR=250):**
  - Stimulus: `i_addr`=8'h12, `i_data`=8'h80.
  - Response: decoded bytes 42,12,80. `o_ready` low for exactly 29,500 cycles. No `o_nack`.
- **Handshake:**
  - Stimulus: hold `i_start`=1 continuously through two transactions (addr 8'h11 then 8'h40).
  - Response: `o_ready` falls at the accepting edge, exactly two transactions are emitted, and there is no duplicate start.
- **Busy request:**
  - Stimulus: pulse `i_start` with addr 8'hFF while busy.
  - Response: ignored; the in-flight bytes are unchanged.
- **X bit:**
  - Stimulus: the slave drives 1 on the X bit of byte 2.
  - Response: `o_siod_oe`=0 during all three X bits; `o_nack` pulses once, coincident with the `o_ready` rise.
- **Protocol checker (runs across all scenarios):** SIOD stable while SIOC=1 except at start/stop; SIOC high and low periods each 2*QTR.
